// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: receive-side VGA timing monitor. Samples HS/VS/COLOUR on
// PIX_EN, recovers line/frame timing, locks to the frame, emits active-region
// pixels with coordinates and flags line/frame length errors.
// Optional build macro: VGA_MON_CHECKSUM_EN adds a per-frame colour checksum
// on FRAME_SUM; without it FRAME_SUM is tied to zero.
module vga_sync_monitor #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PIX_EN,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic [7:0]  VGA_COLOUR,
    output logic [9:0]  PIX_X,
    output logic [9:0]  PIX_Y,
    output logic [7:0]  PIX_DATA,
    output logic        PIX_VALID,
    output logic        FRAME_DONE,
    output logic        LOCKED,
    output logic        H_ERR,
    output logic        V_ERR,
    output logic [7:0]  ERR_COUNT,
    output logic [15:0] FRAME_SUM
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0]  H_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [9:0]  X_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_LAST  = 10'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ACQ    = 2'd1,
        LOCK   = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       hs_now, vs_now, hs_prev, vs_prev, hs_edge, vs_edge;
    logic [9:0] hcnt, vcnt, hcnt_nxt, vcnt_nxt;
    logic [9:0] x_cur, y_cur;
    logic       h_err, v_err, herr_seen, herr_seen_nxt;
    logic       active, pix_ok;

    // Sync levels normalised so that 1 always means "asserted".
    assign hs_now  = VGA_HS ~^ SYNC_POL;
    assign vs_now  = VGA_VS ~^ SYNC_POL;
    assign hs_edge = hs_now & ~hs_prev;
    assign vs_edge = vs_now & ~vs_prev;

    assign x_cur  = hcnt_nxt - H_START;
    assign y_cur  = vcnt_nxt - V_START;
    assign active = (hcnt_nxt >= H_START) && (hcnt_nxt < H_END) &&
                    (vcnt_nxt >= V_START) && (vcnt_nxt < V_END);
    // The error that drops lock also suppresses its own pixel.
    assign pix_ok = PIX_EN && active && (state == LOCK) && !h_err && !v_err;
    assign LOCKED = (state == LOCK);

    // Counter advance, error detection and lock state machine for this sample.
    always_comb begin
        hcnt_nxt      = hcnt;
        vcnt_nxt      = vcnt;
        h_err         = 1'b0;
        v_err         = 1'b0;
        state_nxt     = state;
        herr_seen_nxt = herr_seen;
        if (PIX_EN) begin
            if (hs_edge) begin
                hcnt_nxt = '0;
                if (state != SEARCH && hcnt != H_LAST) h_err = 1'b1;
            end else if (hcnt == H_LAST) begin
                hcnt_nxt = '0;
                h_err    = 1'b1;
            end else begin
                hcnt_nxt = hcnt + 10'd1;
            end

            if (vs_edge) begin
                vcnt_nxt = '0;
                if (state == LOCK && vcnt != V_LAST) v_err = 1'b1;
            end else if (hs_edge) begin
                if (vcnt == V_LAST) begin
                    vcnt_nxt = '0;
                    v_err    = 1'b1;
                end else begin
                    vcnt_nxt = vcnt + 10'd1;
                end
            end

            herr_seen_nxt = herr_seen | h_err;
            case (state)
                SEARCH: begin
                    if (vs_edge) begin
                        state_nxt     = ACQ;
                        herr_seen_nxt = 1'b0;
                    end
                end
                ACQ: begin
                    // Each vs_edge closes one measured frame and opens the next.
                    if (vs_edge) begin
                        if (!herr_seen && !h_err && vcnt == V_LAST) state_nxt = LOCK;
                        herr_seen_nxt = 1'b0;
                    end else if (v_err) begin
                        state_nxt = SEARCH;
                    end
                end
                LOCK: begin
                    if (h_err || v_err) state_nxt = SEARCH;
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    // Timing state: lock FSM, counters and previous sync samples.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= SEARCH;
            hcnt      <= '0;
            vcnt      <= '0;
            herr_seen <= 1'b0;
            hs_prev   <= 1'b0;
            vs_prev   <= 1'b0;
        end else begin
            state     <= state_nxt;
            hcnt      <= hcnt_nxt;
            vcnt      <= vcnt_nxt;
            herr_seen <= herr_seen_nxt;
            if (PIX_EN) begin
                hs_prev <= hs_now;
                vs_prev <= vs_now;
            end
        end
    end

    // Registered pixel, pulse and error-count outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            PIX_X      <= '0;
            PIX_Y      <= '0;
            PIX_DATA   <= '0;
            PIX_VALID  <= 1'b0;
            FRAME_DONE <= 1'b0;
            H_ERR      <= 1'b0;
            V_ERR      <= 1'b0;
            ERR_COUNT  <= '0;
        end else begin
            PIX_VALID  <= pix_ok;
            FRAME_DONE <= pix_ok && (x_cur == X_LAST) && (y_cur == Y_LAST);
            H_ERR      <= h_err;
            V_ERR      <= v_err;
            if (pix_ok) begin
                PIX_X    <= x_cur;
                PIX_Y    <= y_cur;
                PIX_DATA <= VGA_COLOUR;
            end
            if ((h_err || v_err) && ERR_COUNT != 8'hFF) ERR_COUNT <= ERR_COUNT + 8'd1;
        end
    end

`ifdef VGA_MON_CHECKSUM_EN
    logic [15:0] acc;

    // Per-frame colour sum; FRAME_SUM captures it including the final pixel.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc       <= '0;
            FRAME_SUM <= '0;
        end else begin
            if (PIX_EN && vs_edge) acc <= '0;
            else if (PIX_VALID)    acc <= acc + {8'h00, PIX_DATA};
            if (FRAME_DONE) FRAME_SUM <= acc + {8'h00, PIX_DATA};
        end
    end
`else
    assign FRAME_SUM = '0;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: directed bench for vga_sync_monitor using a reduced
// 16x11 raster (8x6 active) so whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_sync_monitor;

    localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 3, H_BP = 3;
    localparam int V_ACTIVE = 6, V_FP = 1, V_SYNC = 2, V_BP = 2;
    localparam int H_TOTAL  = 16;
    localparam int V_TOTAL  = 11;
    localparam int H_START  = 6;
    localparam int V_START  = 4;
    localparam int FRAME_PIX = 48;
`ifdef VGA_MON_CHECKSUM_EN
    localparam logic [15:0] EXP_SUM = 16'd168;  // 6 lines * (0+1+..+7)
`else
    localparam logic [15:0] EXP_SUM = 16'd0;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        PIX_EN = 1'b0;
    logic        VGA_HS = 1'b1;
    logic        VGA_VS = 1'b1;
    logic [7:0]  VGA_COLOUR = 8'h00;
    logic [9:0]  PIX_X, PIX_Y;
    logic [7:0]  PIX_DATA;
    logic        PIX_VALID, FRAME_DONE, LOCKED, H_ERR, V_ERR;
    logic [7:0]  ERR_COUNT;
    logic [15:0] FRAME_SUM;

    int tests_run = 0;
    int tests_failed = 0;
    int gap = 4;
    int colour_mode = 0;
    int frame_no = 0;

    int pv_count = 0, fd_count = 0, herr_count = 0, verr_count = 0;
    int order_err = 0, seen_frame = 0, ex = 0, ey = 0;
    int fd_x = -1, fd_y = -1;
    logic [7:0] exp_col;

    vga_sync_monitor #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(1'b0)
    ) dut (
        .CLK(CLK), .RESET(RESET), .PIX_EN(PIX_EN),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_COLOUR(VGA_COLOUR),
        .PIX_X(PIX_X), .PIX_Y(PIX_Y), .PIX_DATA(PIX_DATA),
        .PIX_VALID(PIX_VALID), .FRAME_DONE(FRAME_DONE), .LOCKED(LOCKED),
        .H_ERR(H_ERR), .V_ERR(V_ERR), .ERR_COUNT(ERR_COUNT), .FRAME_SUM(FRAME_SUM)
    );

    always #5 CLK = ~CLK;

    // Output monitor: counts pulses and checks each pixel against a raster model.
    always @(negedge CLK) begin
        if (frame_no != seen_frame) begin
            seen_frame = frame_no;
            ex = 0;
            ey = 0;
        end
        if (PIX_VALID === 1'b1) begin
            pv_count++;
            exp_col = (colour_mode == 1) ? 8'(ex) : 8'hA5;
            if (PIX_X !== 10'(ex) || PIX_Y !== 10'(ey) || PIX_DATA !== exp_col) order_err++;
            if (FRAME_DONE === 1'b1) begin
                fd_x = int'(PIX_X);
                fd_y = int'(PIX_Y);
            end
            ex++;
            if (ex == H_ACTIVE) begin
                ex = 0;
                ey++;
            end
        end
        if (FRAME_DONE === 1'b1) fd_count++;
        if (H_ERR === 1'b1) herr_count++;
        if (V_ERR === 1'b1) verr_count++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Called at a negedge; one sample with PIX_EN, then gap-1 idle clocks.
    task automatic send_sample(input logic hs_a, input logic vs_a, input logic [7:0] col);
        VGA_HS = ~hs_a;
        VGA_VS = ~vs_a;
        VGA_COLOUR = col;
        PIX_EN = 1'b1;
        @(negedge CLK);
        PIX_EN = 1'b0;
        for (int i = 1; i < gap; i++) @(negedge CLK);
    endtask

    task automatic send_lines(input int first, input int last, input int short_line, input int short_len);
        int len;
        logic [7:0] col;
        if (first == 0) frame_no++;
        for (int l = first; l < last; l++) begin
            len = (l == short_line) ? short_len : H_TOTAL;
            for (int p = 0; p < len; p++) begin
                col = 8'h00;
                if (p >= H_START && p < H_START + H_ACTIVE && l >= V_START && l < V_START + V_ACTIVE)
                    col = (colour_mode == 1) ? 8'(p - H_START) : 8'hA5;
                send_sample(p < H_SYNC, l < V_SYNC, col);
            end
        end
    endtask

    task automatic send_frame();
        send_lines(0, V_TOTAL, -1, 0);
    endtask

    task automatic settle();
        repeat (3) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        PIX_EN = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (PIX_X !== 10'd0 || PIX_Y !== 10'd0 || PIX_DATA !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_pixel: x=%0d y=%0d data=%0h required 0/0/0", PIX_X, PIX_Y, PIX_DATA);
        end
        tests_run++;
        if (PIX_VALID !== 1'b0 || FRAME_DONE !== 1'b0 || LOCKED !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: valid=%0b done=%0b locked=%0b required 0", PIX_VALID, FRAME_DONE, LOCKED);
        end
        tests_run++;
        if (H_ERR !== 1'b0 || V_ERR !== 1'b0 || ERR_COUNT !== 8'd0 || FRAME_SUM !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_err: herr=%0b verr=%0b cnt=%0d sum=%0h required 0", H_ERR, V_ERR, ERR_COUNT, FRAME_SUM);
        end
    endtask

    task automatic test_lock_clean();
        int pv0, fd0, he0, ve0, oe0;
        do_reset();
        gap = 4;
        colour_mode = 0;
        pv0 = pv_count; fd0 = fd_count; he0 = herr_count; ve0 = verr_count; oe0 = order_err;
        send_frame();
        settle();
        tests_run++;
        if (LOCKED !== 1'b0 || pv_count - pv0 != 0) begin
            tests_failed++;
            $display("FAIL lock_frame1: locked=%0b pixels=%0d required 0/0", LOCKED, pv_count - pv0);
        end
        send_lines(0, 1, -1, 0);
        settle();
        tests_run++;
        if (LOCKED !== 1'b1) begin
            tests_failed++;
            $display("FAIL lock_at_vs2: locked=%0b required 1", LOCKED);
        end
        send_lines(1, V_TOTAL, -1, 0);
        settle();
        tests_run++;
        if (pv_count - pv0 != FRAME_PIX || fd_count - fd0 != 1) begin
            tests_failed++;
            $display("FAIL lock_frame2: pixels=%0d done=%0d required %0d/1", pv_count - pv0, fd_count - fd0, FRAME_PIX);
        end
        tests_run++;
        if (fd_x != H_ACTIVE - 1 || fd_y != V_ACTIVE - 1) begin
            tests_failed++;
            $display("FAIL frame_done_xy: x=%0d y=%0d required %0d/%0d", fd_x, fd_y, H_ACTIVE - 1, V_ACTIVE - 1);
        end
        send_frame();
        settle();
        tests_run++;
        if (pv_count - pv0 != 2 * FRAME_PIX || fd_count - fd0 != 2) begin
            tests_failed++;
            $display("FAIL lock_frame3: pixels=%0d done=%0d required %0d/2", pv_count - pv0, fd_count - fd0, 2 * FRAME_PIX);
        end
        tests_run++;
        if (order_err - oe0 != 0) begin
            tests_failed++;
            $display("FAIL pixel_order: bad pixels=%0d required 0", order_err - oe0);
        end
        tests_run++;
        if (herr_count - he0 != 0 || verr_count - ve0 != 0 || ERR_COUNT !== 8'd0 || LOCKED !== 1'b1) begin
            tests_failed++;
            $display("FAIL clean_errs: herr=%0d verr=%0d cnt=%0d locked=%0b required 0/0/0/1",
                     herr_count - he0, verr_count - ve0, ERR_COUNT, LOCKED);
        end
    endtask

    // Continues from the locked state left by test_lock_clean.
    task automatic test_short_line();
        int pv0, fd0, he0, oe0;
        pv0 = pv_count; fd0 = fd_count; he0 = herr_count; oe0 = order_err;
        send_lines(0, V_TOTAL, 5, H_TOTAL - 1);
        settle();
        tests_run++;
        if (herr_count - he0 != 1 || LOCKED !== 1'b0 || ERR_COUNT !== 8'd1) begin
            tests_failed++;
            $display("FAIL short_line_err: herr=%0d locked=%0b cnt=%0d required 1/0/1", herr_count - he0, LOCKED, ERR_COUNT);
        end
        tests_run++;
        if (pv_count - pv0 != 2 * H_ACTIVE || fd_count - fd0 != 0) begin
            tests_failed++;
            $display("FAIL short_line_stop: pixels=%0d done=%0d required %0d/0", pv_count - pv0, fd_count - fd0, 2 * H_ACTIVE);
        end
        send_frame();
        settle();
        tests_run++;
        if (LOCKED !== 1'b0 || pv_count - pv0 != 2 * H_ACTIVE) begin
            tests_failed++;
            $display("FAIL relock_acq: locked=%0b pixels=%0d required 0/%0d", LOCKED, pv_count - pv0, 2 * H_ACTIVE);
        end
        send_frame();
        settle();
        tests_run++;
        if (LOCKED !== 1'b1 || pv_count - pv0 != 2 * H_ACTIVE + FRAME_PIX || fd_count - fd0 != 1 || order_err - oe0 != 0) begin
            tests_failed++;
            $display("FAIL relock: locked=%0b pixels=%0d done=%0d bad=%0d required 1/%0d/1/0",
                     LOCKED, pv_count - pv0, fd_count - fd0, order_err - oe0, 2 * H_ACTIVE + FRAME_PIX);
        end
    endtask

    task automatic test_short_frame();
        int pv0, he0, ve0;
        do_reset();
        gap = 4;
        colour_mode = 0;
        pv0 = pv_count; he0 = herr_count; ve0 = verr_count;
        send_frame();
        send_frame();
        send_lines(0, V_TOTAL - 1, -1, 0);
        settle();
        tests_run++;
        if (verr_count - ve0 != 0 || LOCKED !== 1'b1 || pv_count - pv0 != 2 * FRAME_PIX) begin
            tests_failed++;
            $display("FAIL short_frame_pre: verr=%0d locked=%0b pixels=%0d required 0/1/%0d",
                     verr_count - ve0, LOCKED, pv_count - pv0, 2 * FRAME_PIX);
        end
        send_frame();
        settle();
        tests_run++;
        if (verr_count - ve0 != 1 || herr_count - he0 != 0 || ERR_COUNT !== 8'd1) begin
            tests_failed++;
            $display("FAIL short_frame_verr: verr=%0d herr=%0d cnt=%0d required 1/0/1", verr_count - ve0, herr_count - he0, ERR_COUNT);
        end
        tests_run++;
        if (LOCKED !== 1'b0 || pv_count - pv0 != 2 * FRAME_PIX) begin
            tests_failed++;
            $display("FAIL short_frame_unlock: locked=%0b pixels=%0d required 0/%0d", LOCKED, pv_count - pv0, 2 * FRAME_PIX);
        end
    endtask

    task automatic test_herr_saturate();
        int he0, ve0;
        do_reset();
        gap = 1;
        he0 = herr_count; ve0 = verr_count;
        repeat (H_TOTAL - 1) send_sample(1'b0, 1'b0, 8'h00);
        settle();
        tests_run++;
        if (herr_count - he0 != 0) begin
            tests_failed++;
            $display("FAIL herr_early: herr=%0d required 0", herr_count - he0);
        end
        send_sample(1'b0, 1'b0, 8'h00);
        settle();
        tests_run++;
        if (herr_count - he0 != 1 || ERR_COUNT !== 8'd1) begin
            tests_failed++;
            $display("FAIL herr_first: herr=%0d cnt=%0d required 1/1", herr_count - he0, ERR_COUNT);
        end
        repeat (253 * H_TOTAL) send_sample(1'b0, 1'b0, 8'h00);
        settle();
        tests_run++;
        if (ERR_COUNT !== 8'd254) begin
            tests_failed++;
            $display("FAIL err_count_254: cnt=%0d required 254", ERR_COUNT);
        end
        repeat (H_TOTAL) send_sample(1'b0, 1'b0, 8'h00);
        settle();
        tests_run++;
        if (ERR_COUNT !== 8'd255) begin
            tests_failed++;
            $display("FAIL err_count_255: cnt=%0d required 255", ERR_COUNT);
        end
        repeat (5 * H_TOTAL) send_sample(1'b0, 1'b0, 8'h00);
        settle();
        tests_run++;
        if (ERR_COUNT !== 8'd255 || herr_count - he0 != 260 || verr_count - ve0 != 0 || LOCKED !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_saturate: cnt=%0d herr=%0d verr=%0d locked=%0b required 255/260/0/0",
                     ERR_COUNT, herr_count - he0, verr_count - ve0, LOCKED);
        end
        gap = 4;
    endtask

    task automatic test_reset_midframe();
        int pv0;
        do_reset();
        gap = 4;
        colour_mode = 0;
        pv0 = pv_count;
        send_frame();
        send_frame();
        send_lines(0, 7, -1, 0);
        settle();
        tests_run++;
        if (LOCKED !== 1'b1 || pv_count - pv0 != FRAME_PIX + 3 * H_ACTIVE) begin
            tests_failed++;
            $display("FAIL mid_pre: locked=%0b pixels=%0d required 1/%0d", LOCKED, pv_count - pv0, FRAME_PIX + 3 * H_ACTIVE);
        end
        #2 RESET = 1'b1;
        #1;
        tests_run++;
        if (PIX_X !== 10'd0 || PIX_Y !== 10'd0 || PIX_DATA !== 8'd0 || LOCKED !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: x=%0d y=%0d data=%0h locked=%0b required 0", PIX_X, PIX_Y, PIX_DATA, LOCKED);
        end
        #1 RESET = 1'b0;
        @(negedge CLK);
        send_lines(7, V_TOTAL, -1, 0);
        send_frame();
        settle();
        tests_run++;
        if (LOCKED !== 1'b0 || pv_count - pv0 != FRAME_PIX + 3 * H_ACTIVE) begin
            tests_failed++;
            $display("FAIL mid_no_pixels: locked=%0b pixels=%0d required 0/%0d", LOCKED, pv_count - pv0, FRAME_PIX + 3 * H_ACTIVE);
        end
        send_frame();
        settle();
        tests_run++;
        if (LOCKED !== 1'b1 || pv_count - pv0 != 2 * FRAME_PIX + 3 * H_ACTIVE) begin
            tests_failed++;
            $display("FAIL mid_relock: locked=%0b pixels=%0d required 1/%0d", LOCKED, pv_count - pv0, 2 * FRAME_PIX + 3 * H_ACTIVE);
        end
    endtask

    task automatic test_checksum();
        int oe0;
        do_reset();
        gap = 4;
        colour_mode = 1;
        oe0 = order_err;
        send_frame();
        settle();
        tests_run++;
        if (FRAME_SUM !== 16'd0) begin
            tests_failed++;
            $display("FAIL sum_unlocked: sum=%0h required 0", FRAME_SUM);
        end
        send_frame();
        settle();
        tests_run++;
        if (FRAME_SUM !== EXP_SUM) begin
            tests_failed++;
            $display("FAIL sum_frame2: sum=%0h required %0h", FRAME_SUM, EXP_SUM);
        end
        send_frame();
        settle();
        tests_run++;
        if (FRAME_SUM !== EXP_SUM || order_err - oe0 != 0) begin
            tests_failed++;
            $display("FAIL sum_frame3: sum=%0h bad=%0d required %0h/0", FRAME_SUM, order_err - oe0, EXP_SUM);
        end
        colour_mode = 0;
    endtask

    initial begin
        RESET = 1'b1;
        @(negedge CLK);
        test_reset();
        test_lock_clean();
        test_short_line();
        test_short_frame();
        test_herr_saturate();
        test_reset_midframe();
        test_checksum();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
